// File: rtl/data_memory_unit_pkg.sv
// Shared constants for the data memory unit: bus widths, FSM state encodings
// and the wait-counter width helper.
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif

package data_memory_unit_pkg;

  localparam int DM_STATE_SIZE = 1;
  localparam logic [DM_STATE_SIZE-1:0] DM_IDLE = 1'b0;
  localparam logic [DM_STATE_SIZE-1:0] DM_WAIT = 1'b1;

  function automatic int dm_cnt_width(input int wait_states);
    return (wait_states > 0) ? $clog2(wait_states + 1) : 1;
  endfunction

endpackage

// File: rtl/data_memory_unit_array.sv
// data_memory_array: single-port synchronous RAM with registered read data.
module data_memory_array #(
  parameter int    MEM_ADDR_BITS = 10,
  parameter string INIT_FILE     = ""
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [MEM_ADDR_BITS-1:0] index,
  input  logic [`DATA_SIZE-1:0]    wdata,
  output logic [`DATA_SIZE-1:0]    rdata
);

  localparam int DEPTH = 2 ** MEM_ADDR_BITS;

  logic [`DATA_SIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) r_mem[index] <= wdata;
    rdata <= r_mem[index];
  end

endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: execute-stage data memory responder with configurable wait states.
// Define DATA_MEMORY_BOUNDS_CHECK_EN to fault on addresses beyond the RAM depth.
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int    WAIT_STATES   = 0,
  parameter int    MEM_ADDR_BITS = 10,
  parameter string INIT_FILE     = ""
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic                     write,
  input  logic [`ADDRESS_SIZE-1:0] address,
  input  logic [`DATA_SIZE-1:0]    data_in,
  output logic [`DATA_SIZE-1:0]    data_out,
  output logic                     data_valid,
  output logic                     busy
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  ,
  output logic                     fault
`endif
);

  localparam int CNT_W = dm_cnt_width(WAIT_STATES);

  logic                     w_req;
  logic                     w_addr_oob;
  logic [MEM_ADDR_BITS-1:0] w_index;
  logic                     w_complete;
  logic                     w_cmp_write;
  logic                     w_cmp_read;
  logic                     w_cmp_oob;
  logic [MEM_ADDR_BITS-1:0] w_cmp_index;
  logic [`DATA_SIZE-1:0]    w_cmp_wdata;
  logic                     w_we;
  logic [`DATA_SIZE-1:0]    w_rdata;

  logic                     r_valid;
  logic                     r_load_oob;
  logic [`DATA_SIZE-1:0]    r_hold;

  assign w_req   = read | write;
  assign w_index = address[MEM_ADDR_BITS-1:0];

  generate
    if (MEM_ADDR_BITS < `ADDRESS_SIZE) begin : g_upper
      logic [`ADDRESS_SIZE-MEM_ADDR_BITS-1:0] w_upper;
      assign w_upper = address[`ADDRESS_SIZE-1:MEM_ADDR_BITS];
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
      assign w_addr_oob = |w_upper;
`else
      logic w_unused_upper;
      assign w_unused_upper = ^w_upper;
      assign w_addr_oob     = 1'b0;
`endif
    end else begin : g_full
      assign w_addr_oob = 1'b0;
    end
  endgenerate

  generate
    if (WAIT_STATES == 0) begin : g_single
      // Always idle: every request completes on the edge that accepts it.
      assign busy        = 1'b0;
      assign w_complete  = ~reset & w_req;
      assign w_cmp_write = write;
      assign w_cmp_read  = read & ~write;
      assign w_cmp_oob   = w_addr_oob;
      assign w_cmp_index = w_index;
      assign w_cmp_wdata = data_in;
    end else begin : g_multi
      logic [DM_STATE_SIZE-1:0] r_state;
      logic [CNT_W-1:0]         r_cnt;
      logic                     r_op_write;
      logic                     r_op_read;
      logic                     r_op_oob;
      logic [MEM_ADDR_BITS-1:0] r_index;
      logic [`DATA_SIZE-1:0]    r_wdata;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_state <= DM_IDLE;
          r_cnt   <= '0;
        end else if (r_state == DM_IDLE) begin
          if (w_req) begin
            r_state    <= DM_WAIT;
            r_cnt      <= CNT_W'(WAIT_STATES - 1);
            r_op_write <= write;
            r_op_read  <= read & ~write;
            r_op_oob   <= w_addr_oob;
            r_index    <= w_index;
            r_wdata    <= data_in;
          end
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end else begin
          r_state <= DM_IDLE;
        end
      end

      assign busy        = (r_state == DM_WAIT);
      assign w_complete  = ~reset & (r_state == DM_WAIT) & (r_cnt == '0);
      assign w_cmp_write = r_op_write;
      assign w_cmp_read  = r_op_read;
      assign w_cmp_oob   = r_op_oob;
      assign w_cmp_index = r_index;
      assign w_cmp_wdata = r_wdata;
    end
  endgenerate

  assign w_we = w_complete & w_cmp_write & ~w_cmp_oob;

  data_memory_array #(
    .MEM_ADDR_BITS (MEM_ADDR_BITS),
    .INIT_FILE     (INIT_FILE)
  ) u_array (
    .clock (clock),
    .we    (w_we),
    .index (w_cmp_index),
    .wdata (w_cmp_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_load_oob <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_valid    <= w_complete & w_cmp_read;
      r_load_oob <= w_complete & w_cmp_oob;
      if (r_valid) r_hold <= data_out;
    end
  end

  // The array output is already the registered load; r_hold keeps it stable between loads.
  assign data_out   = r_valid ? (r_load_oob ? '0 : w_rdata) : r_hold;
  assign data_valid = r_valid;

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  logic r_fault;

  always_ff @(posedge clock) begin
    if (reset) r_fault <= 1'b0;
    else       r_fault <= w_complete & w_cmp_oob;
  end

  assign fault = r_fault;
`endif

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: two instances (WAIT_STATES 0 and 3) checked every
// cycle against a transaction-level model, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_data_memory_unit;

  localparam int AW    = `ADDRESS_SIZE;
  localparam int DW    = `DATA_SIZE;
  localparam int MAB   = 10;
  localparam int DEPTH = 2 ** MAB;
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          rst  [2];
  logic          rd   [2];
  logic          wr   [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] din  [2];
  logic [DW-1:0] dout [2];
  logic          vld  [2];
  logic          bsy  [2];
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  logic          flt  [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  data_memory_unit #(.WAIT_STATES(0), .MEM_ADDR_BITS(MAB)) u_ws0 (
    .clock(clock), .reset(rst[0]), .read(rd[0]), .write(wr[0]), .address(addr[0]),
    .data_in(din[0]), .data_out(dout[0]), .data_valid(vld[0]), .busy(bsy[0])
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    , .fault(flt[0])
`endif
  );

  data_memory_unit #(.WAIT_STATES(3), .MEM_ADDR_BITS(MAB)) u_ws3 (
    .clock(clock), .reset(rst[1]), .read(rd[1]), .write(wr[1]), .address(addr[1]),
    .data_in(din[1]), .data_out(dout[1]), .data_valid(vld[1]), .busy(bsy[1])
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    , .fault(flt[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access per instance, completing WS edges after accept.
  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int WS = (g == 0) ? 0 : 3;
    logic [DW-1:0] mem   [DEPTH];
    bit            known [DEPTH];
    bit            pend, p_wr, p_rd, p_oob;
    int unsigned   p_idx, p_done, t;
    bit            e_busy, e_valid, e_fault, e_known;
    logic [DW-1:0] e_dout, p_data;

    initial begin
      for (int unsigned i = 0; i < DEPTH; i++) known[i] = 1'b0;
      pend = 1'b0; t = 0; e_known = 1'b0; e_dout = '0;
      forever begin
        @(posedge clock);
        e_valid = 1'b0;
        e_fault = 1'b0;
        if (rst[g]) begin
          pend    = 1'b0;
          e_dout  = '0;
          e_known = 1'b1;
        end else begin
          if (!pend && (rd[g] || wr[g])) begin
            pend   = 1'b1;
            p_wr   = wr[g];
            p_rd   = rd[g] && !wr[g];
            p_idx  = addr[g] % DEPTH;
            p_oob  = BOUNDS && (addr[g] >= DEPTH);
            p_data = din[g];
            p_done = t + WS;
          end
          if (pend && t == p_done) begin
            if (p_wr && !p_oob) begin
              mem[p_idx]   = p_data;
              known[p_idx] = 1'b1;
            end
            if (p_rd) begin
              e_valid = 1'b1;
              e_dout  = p_oob ? '0 : mem[p_idx];
              e_known = p_oob || known[p_idx];
            end
            e_fault = p_oob;
            pend    = 1'b0;
          end
        end
        e_busy = pend;
        t++;
        #1;
        check($sformatf("ws%0d busy", WS), 32'(bsy[g]), 32'(e_busy));
        check($sformatf("ws%0d data_valid", WS), 32'(vld[g]), 32'(e_valid));
        if (e_known) check($sformatf("ws%0d data_out", WS), 32'(dout[g]), 32'(e_dout));
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        check($sformatf("ws%0d fault", WS), 32'(flt[g]), 32'(e_fault));
`endif
      end
    end
  end

  task automatic drive(input int g, input bit r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    @(negedge clock);
    rd[g] = r; wr[g] = w; addr[g] = a; din[g] = d;
  endtask

  task automatic sample;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    do begin sample(); n++; end while (bsy[g] && n < 50);
    check("wait_idle", 32'(bsy[g]), 32'd0);
  endtask

  task automatic wait_valid(input int g);
    int n = 0;
    do begin sample(); n++; end while (!vld[g] && n < 50);
    check("wait_valid", 32'(vld[g]), 32'd1);
  endtask

  task automatic rand_run(input int g, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      rst[g]  = ($urandom_range(0, 99) == 0);
      rd[g]   = ($urandom_range(0, 2) == 0);
      wr[g]   = ($urandom_range(0, 3) == 0);
      addr[g] = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) addr[g] = addr[g] | (AW'($urandom_range(1, 63)) << MAB);
      din[g]  = DW'($urandom);
    end
    @(negedge clock);
    rst[g] = 1'b0; rd[g] = 1'b0; wr[g] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; rd[g] = 1'b0; wr[g] = 1'b0; addr[g] = '0; din[g] = '0;
    end
    sample();
    for (int g = 0; g < 2; g++) begin
      check("reset busy", 32'(bsy[g]), 32'd0);
      check("reset data_valid", 32'(vld[g]), 32'd0);
      check("reset data_out", 32'(dout[g]), 32'd0);
    end
    @(negedge clock);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // WS=0: store then immediate load
    drive(0, 0, 1, 5, 16'h1234);
    sample();
    check("ws0 store no valid", 32'(vld[0]), 32'd0);
    drive(0, 1, 0, 5, 0);
    sample();
    check("ws0 load valid", 32'(vld[0]), 32'd1);
    check("ws0 load data", 32'(dout[0]), 32'h1234);
    check("ws0 busy", 32'(bsy[0]), 32'd0);

    // read and write together: write wins
    drive(0, 1, 1, 9, 16'h00AA);
    sample();
    check("rw no valid", 32'(vld[0]), 32'd0);
    drive(0, 1, 0, 9, 0);
    sample();
    check("rw load data", 32'(dout[0]), 32'h00AA);
    drive(0, 0, 0, 0, 0);
    sample();
    check("hold valid", 32'(vld[0]), 32'd0);
    check("hold data", 32'(dout[0]), 32'h00AA);

    // upper address bits: aliasing or bounds fault
    drive(0, 0, 1, 1, 16'h3333);
    drive(0, 0, 1, 16'h0401, 16'h7777);
    sample();
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    check("oob store fault", 32'(flt[0]), 32'd1);
`endif
    drive(0, 1, 0, 1, 0);
    sample();
    check("alias load data", 32'(dout[0]), BOUNDS ? 32'h3333 : 32'h7777);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    drive(0, 1, 0, 16'h0400, 0);
    sample();
    check("oob load valid", 32'(vld[0]), 32'd1);
    check("oob load fault", 32'(flt[0]), 32'd1);
    check("oob load data", 32'(dout[0]), 32'd0);
`endif
    drive(0, 0, 0, 0, 0);

    // WS=3: load latency and requests ignored while busy
    drive(1, 0, 1, 7, 16'hBEEF);
    drive(1, 0, 0, 0, 0);
    wait_idle(1);
    drive(1, 1, 0, 7, 0);
    sample();
    check("ws3 busy N+1", 32'(bsy[1]), 32'd1);
    drive(1, 0, 1, 7, 16'h0BAD);
    sample();
    check("ws3 busy N+2", 32'(bsy[1]), 32'd1);
    sample();
    check("ws3 busy N+3", 32'(bsy[1]), 32'd1);
    check("ws3 no early valid", 32'(vld[1]), 32'd0);
    sample();
    check("ws3 valid N+4", 32'(vld[1]), 32'd1);
    check("ws3 data N+4", 32'(dout[1]), 32'hBEEF);
    check("ws3 busy N+4", 32'(bsy[1]), 32'd0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 7, 0);
    drive(1, 0, 0, 0, 0);
    wait_valid(1);
    check("ws3 ignored store", 32'(dout[1]), 32'hBEEF);

    // WS=3: reset during a pending store discards it
    drive(1, 0, 1, 3, 16'h1111);
    drive(1, 0, 0, 0, 0);
    wait_idle(1);
    drive(1, 0, 1, 3, 16'h5555);
    sample();
    check("abort busy before", 32'(bsy[1]), 32'd1);
    @(negedge clock);
    rst[1] = 1'b1; rd[1] = 1'b0; wr[1] = 1'b0;
    sample();
    check("abort busy", 32'(bsy[1]), 32'd0);
    check("abort valid", 32'(vld[1]), 32'd0);
    check("abort data", 32'(dout[1]), 32'd0);
    @(negedge clock);
    rst[1] = 1'b0;
    drive(1, 1, 0, 3, 0);
    drive(1, 0, 0, 0, 0);
    wait_valid(1);
    check("abort old data", 32'(dout[1]), 32'h1111);

    fork
      rand_run(0, 800);
      rand_run(1, 800);
    join

    repeat (6) sample();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
